epb_pes_desc_q: RTL and testbench

//  - Per-traffic-class packet descriptor queue between the Egress Packet Buffer (EPB) and the Packet Egress Scheduler (PES).
//  - EPB enqueues one descriptor per fully-stored packet. PES reads a registered non-empty bitmap, picks a TC and dequeues.
//  - The response returns one cycle after the request.
//  - Lives on the EPB side of the EPB->PES boundary and drives the PES-facing signals.

---
 rtl/epb_pes_pkg.sv | 15 +
 rtl/epb_pes_tc_fifo.sv | 76 +++++++
 rtl/epb_pes_desc_q.sv | 87 ++++++++
 tb/tb_epb_pes_desc_q.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/epb_pes_pkg.sv
// Shared types and default sizing for the EPB->PES descriptor queue.
package epb_pes_pkg;
  localparam int NUM_TC_D = 8;
  localparam int DEPTH_D  = 16;
  localparam int PTR_W_D  = 16;
  localparam int LEN_W_D  = 14;
  localparam int TC_W_D   = $clog2(NUM_TC_D);

  typedef logic [TC_W_D-1:0] tc_id_t;

  typedef struct packed {
    logic [PTR_W_D-1:0] ptr;
    logic [LEN_W_D-1:0] len;
  } epb_pes_desc_t;
endpackage

// File: rtl/epb_pes_tc_fifo.sv
// One traffic-class descriptor FIFO: flop array, pointers, count, registered non-empty flag.
// Optional per-TC byte counter under EPB_PES_BYTE_CNT_EN.
module epb_pes_tc_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 16,
  parameter int LEN_W = 14,
  parameter int CNT_W = $clog2(DEPTH+1),
  parameter int BW    = LEN_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] din_ptr,
  input  logic [LEN_W-1:0] din_len,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic             nonempty,
  output logic [PTR_W-1:0] dout_ptr,
  output logic [LEN_W-1:0] dout_len
`ifdef EPB_PES_BYTE_CNT_EN
  ,
  output logic [BW-1:0]    bytes
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [PTR_W-1:0] mem_ptr [DEPTH];
  logic [LEN_W-1:0] mem_len [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign dout_ptr = mem_ptr[rp];
  assign dout_len = mem_len[rp];

  always_comb begin
    cnt_nxt = cnt;
    case ({wr_en, rd_en})
      2'b10:   cnt_nxt = cnt + CNT_W'(1);
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_ptr[wp] <= din_ptr;
      mem_len[wp] <= din_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      nonempty <= 1'b0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (rd_en) rp <= rp + AW'(1);
      cnt      <= cnt_nxt;
      nonempty <= (cnt_nxt != '0);
    end
  end

`ifdef EPB_PES_BYTE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bytes <= '0;
    else        bytes <= bytes + (wr_en ? BW'(din_len) : BW'(0))
                               - (rd_en ? BW'(dout_len) : BW'(0));
  end
`endif
endmodule

// File: rtl/epb_pes_desc_q.sv
// Per-TC packet descriptor queue, EPB enqueue side / PES dequeue side.
// Define EPB_PES_BYTE_CNT_EN to add per-TC queued-byte counters on tc_bytes.
module epb_pes_desc_q
  import epb_pes_pkg::*;
#(
  parameter int NUM_TC = NUM_TC_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int PTR_W  = PTR_W_D,
  parameter int LEN_W  = LEN_W_D,
  localparam int TC_W  = $clog2(NUM_TC),
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int BW    = LEN_W + CNT_W
) (
  input  logic                 cclk,
  input  logic                 rst_n,
  input  logic                 enq_vld,
  output logic                 enq_rdy,
  input  logic [TC_W-1:0]      enq_tc,
  input  logic [PTR_W-1:0]     enq_ptr,
  input  logic [LEN_W-1:0]     enq_len,
  output logic [NUM_TC-1:0]    tc_nonempty,
  input  logic                 deq_req,
  input  logic [TC_W-1:0]      deq_tc,
  output logic                 deq_rsp_vld,
  output logic [TC_W-1:0]      deq_rsp_tc,
  output logic [PTR_W-1:0]     deq_rsp_ptr,
  output logic [LEN_W-1:0]     deq_rsp_len,
  output logic                 deq_err
`ifdef EPB_PES_BYTE_CNT_EN
  ,
  output logic [NUM_TC*BW-1:0] tc_bytes
`endif
);
  logic [NUM_TC-1:0]            full, empty, wr_en, rd_en;
  logic [NUM_TC-1:0][PTR_W-1:0] head_ptr;
  logic [NUM_TC-1:0][LEN_W-1:0] head_len;
`ifdef EPB_PES_BYTE_CNT_EN
  logic [NUM_TC-1:0][BW-1:0]    bytes;
  assign tc_bytes = bytes;
`endif

  // Full blocks enqueue regardless of a same-cycle dequeue; empty blocks dequeue (no bypass).
  assign enq_rdy = !full[enq_tc];

  for (genvar g = 0; g < NUM_TC; g++) begin : g_tc
    assign wr_en[g] = enq_vld && enq_rdy && (enq_tc == TC_W'(g));
    assign rd_en[g] = deq_req && !empty[g] && (deq_tc == TC_W'(g));

    epb_pes_tc_fifo #(
      .DEPTH(DEPTH), .PTR_W(PTR_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .BW(BW)
    ) u_fifo (
      .clk      (cclk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[g]),
      .din_ptr  (enq_ptr),
      .din_len  (enq_len),
      .rd_en    (rd_en[g]),
      .full     (full[g]),
      .empty    (empty[g]),
      .nonempty (tc_nonempty[g]),
      .dout_ptr (head_ptr[g]),
      .dout_len (head_len[g])
`ifdef EPB_PES_BYTE_CNT_EN
      ,
      .bytes    (bytes[g])
`endif
    );
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      deq_rsp_vld <= 1'b0;
      deq_err     <= 1'b0;
      deq_rsp_tc  <= '0;
      deq_rsp_ptr <= '0;
      deq_rsp_len <= '0;
    end else begin
      deq_rsp_vld <= deq_req && !empty[deq_tc];
      deq_err     <= deq_req &&  empty[deq_tc];
      if (deq_req) deq_rsp_tc <= deq_tc;
      if (deq_req && !empty[deq_tc]) begin
        deq_rsp_ptr <= head_ptr[deq_tc];
        deq_rsp_len <= head_len[deq_tc];
      end
    end
  end
endmodule

// File: tb/tb_epb_pes_desc_q.sv
// Self-checking bench for epb_pes_desc_q against a queue-per-TC reference model.
`timescale 1ns/1ps
module tb_epb_pes_desc_q;
  import epb_pes_pkg::*;
  localparam int NT = 8, DP = 16, BWT = 14 + 5;

  logic        cclk, rst_n;
  logic        enq_vld, enq_rdy, deq_req, deq_rsp_vld, deq_err;
  logic [2:0]  enq_tc, deq_tc, deq_rsp_tc;
  logic [15:0] enq_ptr, deq_rsp_ptr;
  logic [13:0] enq_len, deq_rsp_len;
  logic [7:0]  tc_nonempty;
`ifdef EPB_PES_BYTE_CNT_EN
  logic [NT*BWT-1:0] tc_bytes;
`endif

  int errors = 0;
  int checks = 0;
  epb_pes_desc_t q [NT][$];

  epb_pes_desc_q dut (
    .cclk(cclk), .rst_n(rst_n),
    .enq_vld(enq_vld), .enq_rdy(enq_rdy), .enq_tc(enq_tc),
    .enq_ptr(enq_ptr), .enq_len(enq_len), .tc_nonempty(tc_nonempty),
    .deq_req(deq_req), .deq_tc(deq_tc), .deq_rsp_vld(deq_rsp_vld),
    .deq_rsp_tc(deq_rsp_tc), .deq_rsp_ptr(deq_rsp_ptr),
    .deq_rsp_len(deq_rsp_len), .deq_err(deq_err)
`ifdef EPB_PES_BYTE_CNT_EN
    , .tc_bytes(tc_bytes)
`endif
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic check_state(input string tag);
    logic [7:0] exp_ne;
    for (int i = 0; i < NT; i++) exp_ne[i] = (q[i].size() > 0);
    checks++;
    if (tc_nonempty !== exp_ne) begin
      errors++; $display("FAIL %s tc_nonempty got %h exp %h", tag, tc_nonempty, exp_ne);
    end
`ifdef EPB_PES_BYTE_CNT_EN
    for (int i = 0; i < NT; i++) begin
      int sum = 0;
      foreach (q[i][k]) sum += int'(q[i][k].len);
      checks++;
      if (tc_bytes[i*BWT +: BWT] !== BWT'(sum)) begin
        errors++; $display("FAIL %s tc_bytes[%0d] got %0d exp %0d", tag, i, tc_bytes[i*BWT +: BWT], sum);
      end
    end
`endif
  endtask

  // Inputs already driven; predict, clock once, then compare.
  task automatic do_cycle(input string tag);
    bit exp_rdy, exp_rsp, exp_err;
    epb_pes_desc_t exp_d, nd;
    tc_id_t exp_tc;
    #1;
    exp_rdy = (q[enq_tc].size() < DP);
    checks++;
    if (enq_rdy !== exp_rdy) begin
      errors++; $display("FAIL %s enq_rdy got %b exp %b", tag, enq_rdy, exp_rdy);
    end
    exp_rsp = 0; exp_err = 0; exp_d = '0; exp_tc = '0;
    if (deq_req) begin
      if (q[deq_tc].size() > 0) begin
        exp_rsp = 1; exp_d = q[deq_tc].pop_front(); exp_tc = deq_tc;
      end else exp_err = 1;
    end
    if (enq_vld && exp_rdy) begin
      nd.ptr = enq_ptr; nd.len = enq_len; q[enq_tc].push_back(nd);
    end
    @(posedge cclk); #1;
    enq_vld = 0; deq_req = 0;
    checks++;
    if (deq_rsp_vld !== exp_rsp || deq_err !== exp_err) begin
      errors++; $display("FAIL %s vld/err got %b/%b exp %b/%b", tag, deq_rsp_vld, deq_err, exp_rsp, exp_err);
    end
    if (exp_rsp) begin
      checks++;
      if (deq_rsp_ptr !== exp_d.ptr || deq_rsp_len !== exp_d.len || deq_rsp_tc !== exp_tc) begin
        errors++; $display("FAIL %s rsp got tc%0d %h/%0d exp tc%0d %h/%0d", tag,
                           deq_rsp_tc, deq_rsp_ptr, deq_rsp_len, exp_tc, exp_d.ptr, exp_d.len);
      end
    end
    check_state(tag);
  endtask

  task automatic drive(input bit ev, input int et, input int ep, input int el,
                       input bit dr, input int dt, input string tag);
    enq_vld = ev; enq_tc = 3'(et); enq_ptr = 16'(ep); enq_len = 14'(el);
    deq_req = dr; deq_tc = 3'(dt);
    do_cycle(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (deq_rsp_vld !== 1'b0 || deq_err !== 1'b0 || deq_rsp_tc !== 3'd0 ||
        deq_rsp_ptr !== 16'd0 || deq_rsp_len !== 14'd0) begin
      errors++; $display("FAIL %s rsp regs got vld%b err%b tc%0d %h/%0d exp all 0", tag,
                         deq_rsp_vld, deq_err, deq_rsp_tc, deq_rsp_ptr, deq_rsp_len);
    end
    check_state(tag);
  endtask

  task automatic test_reset();
    rst_n = 0; enq_vld = 0; deq_req = 0; enq_tc = 0; deq_tc = 0; enq_ptr = 0; enq_len = 0;
    repeat (2) @(posedge cclk);
    #1;
    check_reset_outputs("reset");
    checks++;
    if (enq_rdy !== 1'b1) begin
      errors++; $display("FAIL reset enq_rdy got %b exp 1", enq_rdy);
    end
    #3 rst_n = 1;
    @(posedge cclk); #1;
  endtask

  task automatic test_basic();
    drive(1, 3, 'h0100, 64, 0, 0, "basic_enq");
    drive(0, 0, 0, 0, 1, 3, "basic_deq");
  endtask

  task automatic test_fill();
    for (int i = 0; i < DP; i++) drive(1, 0, 'h1000 + i, 10 + i, 0, 0, "fill_enq");
    drive(0, 0, 0, 0, 0, 0, "fill_rdy_tc0");
    drive(0, 1, 0, 0, 0, 0, "fill_rdy_tc1");
    drive(1, 0, 'h2000, 99, 0, 0, "fill_held");
    drive(1, 0, 'h2000, 99, 1, 0, "fill_full_deq");
    drive(1, 0, 'h2000, 99, 0, 0, "fill_accept");
    for (int i = 0; i < DP; i++) drive(0, 0, 0, 0, 1, 0, "fill_drain");
  endtask

  task automatic test_empty_err();
    drive(0, 0, 0, 0, 1, 5, "err_tc5");
    drive(1, 4, 'h4444, 7, 1, 4, "err_no_bypass");
    drive(0, 0, 0, 0, 1, 4, "err_drain_tc4");
  endtask

  task automatic test_same_cycle();
    drive(1, 2, 'hAAAA, 11, 0, 0, "same_enq");
    drive(1, 2, 'hBBBB, 22, 1, 2, "same_both");
    drive(1, 6, 'h6666, 66, 1, 2, "same_other_tc");
    drive(0, 0, 0, 0, 1, 6, "same_drain6");
    drive(0, 0, 0, 0, 1, 2, "same_deq_empty");
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 40; i++) begin
      drive(1, 7, 'h7000 + i, i, 0, 0, "wrap_enq");
      drive(0, 0, 0, 0, 1, 7, "wrap_deq");
    end
  endtask

  task automatic test_random();
    bit ev, dr, hold;
    int et, ep, el, dt;
    hold = 0; et = 0; ep = 0; el = 0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        ev = ($urandom_range(0, 9) < 7);
        et = $urandom_range(0, 3);
        ep = $urandom_range(0, 16'hFFFF);
        el = $urandom_range(0, 14'h3FFF);
      end
      dr = ($urandom_range(0, 9) < 4);
      dt = $urandom_range(0, 3);
      // EPB keeps a stalled descriptor stable until it is taken.
      hold = ev && (q[et].size() >= DP) && !(dr && dt == et);
      drive(ev, et, ep, el, dr, dt, "random");
    end
    for (int t = 0; t < 4; t++)
      while (q[t].size() > 0) drive(0, 0, 0, 0, 1, t, "random_drain");
  endtask

  task automatic test_mid_reset();
    drive(1, 1, 'h0111, 100, 0, 0, "bytes_enq100");
    drive(1, 1, 'h0222, 200, 0, 0, "bytes_enq200");
    drive(0, 0, 0, 0, 1, 1, "bytes_deq");
    drive(1, 5, 'h0555, 55, 0, 0, "mid_enq5");
    enq_vld = 0; deq_req = 1; deq_tc = 3'd1;
    @(posedge cclk); #1;
    deq_req = 0;
    checks++;
    if (deq_rsp_vld !== 1'b1 || deq_rsp_len !== 14'd200) begin
      errors++; $display("FAIL mid_pending got vld%b len%0d exp vld1 len200", deq_rsp_vld, deq_rsp_len);
    end
    #2 rst_n = 0;
    for (int i = 0; i < NT; i++) q[i].delete();
    #1;
    check_reset_outputs("mid_reset");
    #2 rst_n = 1;
    @(posedge cclk); #1;
    drive(0, 0, 0, 0, 1, 5, "post_reset_err");
    drive(1, 5, 'h0AB0, 33, 0, 0, "post_reset_enq");
    drive(0, 0, 0, 0, 1, 5, "post_reset_deq");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_empty_err();
    test_same_cycle();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
